// File: rtl/imem_loader_if.sv
// imem_loader_if: program word stream into the loader and byte write bus out to instruction memory
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic [31:0] word_in;
  logic word_valid;
  logic word_last;
  logic word_ready;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_data;
  modport master (output word_in, word_valid, word_last, input word_ready, mem_we, mem_addr, mem_data);
  modport slave (input word_in, word_valid, word_last, output word_ready, mem_we, mem_addr, mem_data);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: splits 32-bit program words into big-endian byte writes and holds cpu_R until loaded
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W = 7
) (
  input  logic clk,
  input  logic R,
  input  logic start,
  input  logic [ADDR_W-1:0] start_addr,
  imem_loader_if.slave bus,
  output logic cpu_R,
  output logic busy,
  output logic done,
  output logic overflow,
  output logic [CNT_W-1:0] word_count
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WAIT = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] OVF = 3'd4;
  logic [2:0] state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, mem_addr_q, mem_addr_d;
  logic [1:0] idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic last_q, last_d, mem_we_q, mem_we_d, cpu_r_q, cpu_r_d;
  logic [7:0] mem_data_q, mem_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // word_q is shifted left each byte so the next byte to write is always word_q[31:24]
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    word_d = word_q;
    last_d = last_q;
    cnt_d = cnt_q;
    mem_we_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      IDLE, DONE, OVF: if (start) begin
        state_d = WAIT;
        ptr_d = start_addr & ~ADDR_W'(3);
        cnt_d = '0;
      end
      WAIT: if (bus.word_valid) begin
        state_d = WRITE;
        idx_d = 2'd0;
        last_d = bus.word_last;
        word_d = {bus.word_in[23:0], 8'h00};
        mem_we_d = 1'b1;
        mem_addr_d = ptr_q;
        mem_data_d = bus.word_in[31:24];
      end
      WRITE: if (idx_q != 2'd3) begin
        idx_d = idx_q + 2'd1;
        word_d = {word_q[23:0], 8'h00};
        mem_we_d = 1'b1;
        mem_addr_d = mem_addr_q + ADDR_W'(1);
        mem_data_d = word_q[31:24];
      end else begin
        ptr_d = ptr_q + ADDR_W'(4);
        cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
        state_d = last_q ? DONE : ~|ptr_d ? OVF : WAIT;
      end
      default: state_d = IDLE;
    endcase
    cpu_r_d = state_d != DONE;
  end
  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      word_q <= '0;
      last_q <= 1'b0;
      cnt_q <= '0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cpu_r_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      word_q <= word_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      cpu_r_q <= cpu_r_d;
    end
  end
  assign bus.word_ready = state_q == WAIT;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign cpu_R = cpu_r_q;
  assign busy = state_q == WAIT || state_q == WRITE;
  assign done = state_q == DONE;
  assign overflow = state_q == OVF;
  assign word_count = cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads with a write scoreboard checked by a forked bus monitor
module tb_imem_loader;
  logic clk = 1'b0;
  logic R = 1'b1;
  logic start = 1'b0;
  logic [7:0] start_addr = '0;
  logic cpu_R, busy, done, overflow;
  logic [6:0] word_count;
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  imem_loader_if #(.ADDR_W(8)) bus ();
  imem_loader #(.ADDR_W(8), .CNT_W(7)) dut (
    .clk(clk), .R(R), .start(start), .start_addr(start_addr), .bus(bus),
    .cpu_R(cpu_R), .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_write", {bus.mem_addr, bus.mem_data}, 16'hxxxx);
        else begin
          e = exp_q.pop_front();
          check("write", {16'h0, bus.mem_addr, bus.mem_data}, {16'h0, e});
        end
      end
    end
  endtask
  task automatic push_word(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back({a + 8'(i), w[31 - 8 * i -: 8]});
  endtask
  task automatic send(input logic [7:0] a, input logic [31:0] w, input logic last, output int low);
    bus.word_in = w;
    bus.word_last = last;
    bus.word_valid = 1'b1;
    for (int k = 0; k < 30 && bus.word_ready !== 1'b1; k++) tick();
    check("ready_before_send", {31'h0, bus.word_ready}, 32'h1);
    push_word(a, w);
    tick();
    bus.word_valid = 1'b0;
    low = 0;
    while (bus.word_ready !== 1'b1 && !done && !overflow && low < 30) begin
      tick();
      low++;
    end
  endtask
  task automatic wait_end();
    for (int k = 0; k < 30 && !done && !overflow; k++) tick();
  endtask
  task automatic do_start(input logic [7:0] a);
    start = 1'b1;
    start_addr = a;
    tick();
    start = 1'b0;
  endtask
  int low;
  initial begin
    bus.word_in = '0;
    bus.word_valid = 1'b0;
    bus.word_last = 1'b0;
    fork monitor(); join_none
    tick();
    tick();
    check("rst_ready", {31'h0, bus.word_ready}, 0);
    check("rst_we", {31'h0, bus.mem_we}, 0);
    check("rst_addr_data", {16'h0, bus.mem_addr, bus.mem_data}, 0);
    check("rst_flags", {28'h0, busy, done, overflow, cpu_R}, 32'h1);
    check("rst_count", {25'h0, word_count}, 0);
    R = 1'b0;
    bus.word_valid = 1'b1;
    repeat (3) tick();
    bus.word_valid = 1'b0;
    check("idle_ready", {31'h0, bus.word_ready}, 0);
    do_start(8'h00);
    check("t2_busy_ready", {30'h0, busy, bus.word_ready}, 32'h3);
    send(8'h00, 32'hE3A01005, 1'b0, low);
    send(8'h04, 32'hE0812002, 1'b1, low);
    wait_end();
    check("t2_done_cpuR", {30'h0, done, cpu_R}, 32'h2);
    check("t2_count", {25'h0, word_count}, 2);
    do_start(8'h13);
    for (int i = 0; i < 3; i++) begin
      check("t3_idle_ready", {31'h0, bus.word_ready}, 1);
      tick();
    end
    send(8'h10, 32'h01234567, 1'b0, low);
    check("t3_low_cycles", low, 4);
    send(8'h14, 32'h89ABCDEF, 1'b1, low);
    wait_end();
    check("t3_done_count", {24'h0, done, word_count}, {24'h0, 1'b1, 7'd2});
    do_start(8'hF8);
    send(8'hF8, 32'h11223344, 1'b0, low);
    send(8'hFC, 32'h55667788, 1'b0, low);
    wait_end();
    bus.word_in = 32'hDEADBEEF;
    bus.word_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("t4_ovf_ready", {31'h0, bus.word_ready}, 0);
    bus.word_valid = 1'b0;
    check("t4_flags", {29'h0, overflow, done, cpu_R}, 32'h5);
    check("t4_count", {25'h0, word_count}, 2);
    do_start(8'h20);
    bus.word_in = 32'hA1B2C3D4;
    bus.word_last = 1'b0;
    bus.word_valid = 1'b1;
    for (int k = 0; k < 30 && bus.word_ready !== 1'b1; k++) tick();
    exp_q.push_back(16'h20A1);
    exp_q.push_back(16'h21B2);
    exp_q.push_back(16'h22C3);
    tick();
    bus.word_valid = 1'b0;
    tick();
    tick();
    check("t5_byte2_addr", {24'h0, bus.mem_addr}, 32'h22);
    R = 1'b1;
    tick();
    R = 1'b0;
    check("t5_rst_we", {31'h0, bus.mem_we}, 0);
    check("t5_rst_flags", {29'h0, busy, done, cpu_R}, 32'h1);
    do_start(8'h30);
    bus.word_in = 32'h0F1E2D3C;
    bus.word_valid = 1'b1;
    push_word(8'h30, 32'h0F1E2D3C);
    tick();
    bus.word_valid = 1'b0;
    tick();
    do_start(8'h80);
    wait (bus.word_ready === 1'b1 || $time > 2000000);
    #1;
    check("t5_ignored_count", {25'h0, word_count}, 1);
    send(8'h34, 32'h4B5A6978, 1'b1, low);
    wait_end();
    check("t5_done_count", {24'h0, done, word_count}, {24'h0, 1'b1, 7'd2});
    do_start(8'h40);
    check("t6_restart", {23'h0, done, cpu_R, word_count}, {23'h0, 1'b0, 1'b1, 7'd0});
    send(8'h40, 32'hCAFEF00D, 1'b1, low);
    wait_end();
    check("t6_done", {30'h0, done, cpu_R}, 32'h2);
    check("t6_count", {25'h0, word_count}, 1);
    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
